sobel_window_gen: RTL
=====================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter IMG_W, default 100, pixels per image row (>=3).
REQ-002 Parameter IMG_H, default 100, rows per image frame (>=3).
REQ-003 sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  grey pixel byte from the UART receive path, raster order.
REQ-006 in_flag  input  1  one-cycle strobe qualifying data_in; back-to-back strobes allowed.
REQ-007 win_data  output  72  3x3 window, p00 in [71:64] through p22 in [7:0], row-major (r0 oldest row, c0 oldest column).
REQ-008 out_flag  output  1  one-cycle strobe qualifying win_data, win_x and win_y.
REQ-009 win_x  output  10  column of the window centre pixel.
REQ-010 win_y  output  10  row of the window centre pixel.
REQ-011 frame_done  output  1  one-cycle strobe on acceptance of the last pixel of a frame.

Function
REQ-012 col_cnt (0..IMG_W-1) and row_cnt (0..IMG_H-1) SHALL track the position of the pixel accepted on each in_flag.
REQ-013 col_cnt SHALL wrap from IMG_W-1 to 0, incrementing row_cnt; row_cnt SHALL wrap from IMG_H-1 to 0.
REQ-014 Two line buffers, IMG_W x 8 each: lb1 holds row y-1, lb2 holds row y-2, both addressed by col_cnt.
REQ-015 On accepted pixel: column {lb2[col], lb1[col], data_in} is read, then lb2[col]<=lb1[col] and lb1[col]<=data_in in the same cycle.
REQ-016 That column SHALL shift into the window: c0<=c1, c1<=c2, c2<=new column (top = lb2 value, bottom = data_in).
REQ-017 When in_flag is low, counters, buffers and window SHALL hold.
REQ-018 out_flag SHALL pulse exactly one cycle after an accepted pixel with row_cnt>=2 and col_cnt>=2; otherwise 0.
REQ-019 Latency: win_data, win_x=col_cnt-1 and win_y=row_cnt-1 are registered, valid in the out_flag cycle, and held until the next out_flag.
REQ-020 Windows per frame SHALL be exactly (IMG_W-2)*(IMG_H-2); edge pixels produce none. Stale columns from the previous row never appear in a flagged window.
REQ-021 frame_done SHALL pulse one cycle after accepting the pixel at (IMG_W-1, IMG_H-1), coincident with that pixel's out_flag.
REQ-022 Next frame SHALL start at (0,0) with no gap cycles required; buffer contents carried over from the prior frame SHALL NOT affect flagged windows.
REQ-023 Line-buffer reads are combinational; no read-before-write hazard at the same address within one cycle.

Reset
REQ-024 While sys_rst is high: col_cnt, row_cnt, window registers, win_data, win_x and win_y SHALL be 0.
REQ-025 While sys_rst is high: out_flag and frame_done SHALL be 0.
REQ-026 in_flag asserted in the same cycle as sys_rst SHALL be ignored.
REQ-027 Line buffer contents are not reset; REQ-018 gating makes them irrelevant.
REQ-028 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0).

Verification (IMG_W=4, IMG_H=3, frame = bytes 0..11 raster)
REQ-029 Back-to-back in_flag, bytes 0..11: two out_flags are required.
  - First window: win_data = 00,01,02,04,05,06,08,09,0A; win_x=1, win_y=1.
  - Second window: win_data = 01,02,03,05,06,07,09,0A,0B; win_x=2, win_y=1.
  - frame_done coincides with the second out_flag.
REQ-030 Same frame with 3 idle cycles between strobes: identical windows, coordinates and frame_done; each out_flag is 1 cycle after its strobe.
REQ-031 Two consecutive frames, second = bytes 0x20..0x2B: second frame's first window = 20,21,22,24,25,26,28,29,2A; no out_flag during rows 0-1 of frame two.
REQ-032 Reset after 6 pixels, then full frame 0..11: exactly the two windows of REQ-029; no out_flag before pixel 10.
REQ-033 in_flag high with data 0xFF during the sys_rst cycle, then frame 0..11: results identical to REQ-029.
REQ-034 Bench SHALL check that out_flag is never asserted for col_cnt<2 or row_cnt<2 across all of the above.

Source files
------------

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streams raster pixels into a 3x3 window with two line buffers
module sobel_window_gen #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  data_in,
  input  logic        in_flag,
  output logic [71:0] win_data,
  output logic        out_flag,
  output logic [9:0]  win_x,
  output logic [9:0]  win_y,
  output logic        frame_done
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
  logic [9:0]  col_cnt, row_cnt;
  logic [7:0]  lb1 [IMG_W];
  logic [7:0]  lb2 [IMG_W];
  logic [23:0] c0, c1, c2, col_new;
  logic        accept, last_col, last_row, in_core;
  logic [AW-1:0] idx;
  assign idx      = col_cnt[AW-1:0];
  assign accept   = in_flag & ~sys_rst;
  assign last_col = col_cnt == COL_LAST;
  assign last_row = row_cnt == ROW_LAST;
  assign in_core  = (col_cnt >= 10'd2) && (row_cnt >= 10'd2);
  assign col_new  = {lb2[idx], lb1[idx], data_in};
  // line buffers age one row per accepted pixel; contents are never reset because windows are gated
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      lb2[idx] <= lb1[idx];
      lb1[idx] <= data_in;
    end
  end
  // position counters, column shift window and registered window outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      c0         <= '0;
      c1         <= '0;
      c2         <= '0;
      win_data   <= '0;
      win_x      <= '0;
      win_y      <= '0;
      out_flag   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_flag   <= in_flag & in_core;
      frame_done <= in_flag & last_col & last_row;
      if (in_flag) begin
        c0      <= c1;
        c1      <= c2;
        c2      <= col_new;
        col_cnt <= last_col ? '0 : col_cnt + 10'd1;
        row_cnt <= last_col ? (last_row ? '0 : row_cnt + 10'd1) : row_cnt;
        if (in_core) begin
          win_data <= {c1[23:16], c2[23:16], col_new[23:16],
                       c1[15:8],  c2[15:8],  col_new[15:8],
                       c1[7:0],   c2[7:0],   col_new[7:0]};
          win_x    <= col_cnt - 10'd1;
          win_y    <= row_cnt - 10'd1;
        end
      end
    end
  end
endmodule
